dispensador_bebidas_param: RTL
==============================

Name: dispensador_bebidas_param

Overview:
Parametrised successor to the two-level buffet drink-dispenser control (main menu FSM plus category sub-menu FSM), merged into one block.
- Generalised to NCAT categories of NBEB drinks each.
- Adds a timed pour, an inactivity timeout, a per-category age-check mask and a timed denial state.
- Sits between the front-panel buttons/ID reader and the valve drivers; `despacho` drives one valve per drink.

Parameters:
- NCAT, 4: number of drink categories (2..8).
- NBEB, 2: drinks per category (2..4).
- ALC_MASK, 4'b0001: bit c=1 marks category c as alcoholic (width NCAT).
- POUR_CYC, 4: cycles a valve is held open (>=1).
- DENY_CYC, 2: cycles spent in DENY (>=1).
- TIMEOUT_CYC, 16: inactivity cycles in MENU/SUB before returning to IDLE (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start / confirm button.
- back  in  1  return from sub-menu to main menu.
- mayor  in  1  valid adult ID presented.
- cat_sel  in  NCAT  category buttons, must be one-hot to act.
- bev_sel  in  NBEB  drink buttons, must be one-hot to act.
- display  out  3  state code: 0 IDLE, 1 MENU, 2 SUB, 3 POUR, 4 DENY.
- cat_idx  out  $clog2(NCAT)  latched category index.
- despacho  out  NCAT*NBEB  one-hot valve enables.
- busy  out  1  high in POUR or DENY.

Behaviour:
- Reset asserted: state IDLE; display=0, cat_idx=0, despacho=0, busy=0; age_ok=0; all counters 0. Takes effect immediately, including mid-pour, and closes valves without waiting for a clock.
- All outputs are Moore, decoded from registered state and latches. Every transition happens on the clock edge that samples the triggering input.
- IDLE:
  - start=1 -> MENU.
  - All other inputs are ignored.
- MENU:
  - cat_sel exactly one-hot -> SUB, latch cat_idx.
  - cat_sel zero or multi-hot -> stay.
  - back is ignored.
- SUB:
  - back=1 -> MENU. back has priority over start.
  - start=1 with bev_sel one-hot:
    - category alcoholic (ALC_MASK[cat_idx]) and age_ok=0 -> DENY.
    - otherwise -> POUR, latching bev_idx.
  - start=1 with bev_sel zero or multi-hot -> stay.
  - mayor=1 sets age_ok. A mayor and start in the same cycle count: combinational OR into the check.
- age_ok is sticky until the next entry into IDLE.
- POUR:
  - despacho[cat_idx*NBEB+bev_idx]=1 for exactly POUR_CYC cycles; busy=1.
  - Then -> IDLE.
  - All inputs are ignored.
- DENY: despacho=0, busy=1 for DENY_CYC cycles, then -> SUB. cat_idx is kept.
- Inactivity timeout:
  - The counter runs only in MENU/SUB.
  - It clears on state entry and on any cycle where any of start, back, mayor, cat_sel or bev_sel is nonzero.
  - Reaching TIMEOUT_CYC-1 forces IDLE on the next edge; this has lowest priority.
- Counter widths are $clog2(max+1). There is no wrap: each counter saturates and is cleared on state exit.

Optional Feature:
DISPENSADOR_STOCK_EN.
- When defined:
  - Adds parameter STOCK_INIT (default 3).
  - Each drink gets a stock counter loaded with STOCK_INIT on reset.
  - The counter decrements on POUR entry.
  - A SUB confirm on a drink with stock 0 -> DENY. Stock is checked after the age check.
  - Adds output agotado[NCAT*NBEB]: stock==0 flags, reset value 0 when STOCK_INIT>0.
- When undefined: no counters, no agotado port, stock is unlimited.

Decomposition:
- Package dispensador_pkg holds:
  - the state encoding constants (S_IDLE..S_DENY = display codes 0..4);
  - the helper function es_onehot;
  - the index-to-valve mapping function.
- One sub-module, dispensador_temporizador: a load/count/expire counter parametrised by width. It is instantiated for POUR, DENY and timeout.

Test Plan:
1. Reset, then cat_sel=4'b0001, bev_sel=2'b01, mayor=1 with start=0 for 5 cycles -> display stays 0, despacho=0.
2. start -> MENU; cat_sel=4'b0010 -> SUB, cat_idx=1; back -> MENU (display=1). Repeat the enter/back sequence for each category.
3. Soda pour, cat 1:
   - bev_sel=2'b11 with start -> stays SUB.
   - bev_sel=2'b10 with start -> POUR, despacho=8'b0000_1000 for 4 cycles, busy=1.
   - Then IDLE with despacho=0.
4. Alcohol, cat 0:
   - Confirm without mayor -> DENY 2 cycles -> SUB.
   - mayor=1 one cycle, then confirm bev 2'b01 -> despacho=8'b0000_0001 for 4 cycles.
   - Next session the same confirm is denied again (age_ok cleared).
5. Hold all inputs 0 in SUB for 16 cycles -> IDLE. Any input pulse at cycle 10 restarts the count. Reset pulsed mid-POUR -> despacho=0 asynchronously.
6. With DISPENSADOR_STOCK_EN and STOCK_INIT=1: pour cat 2 bev 0 -> agotado[4]=1. The second confirm of that drink -> DENY.

Source files
------------

// File: rtl/dispensador_pkg.sv
// dispensador_pkg: shared definitions for the parametrised drink dispenser.
//   estado_t  : state encoding, values equal the display codes 0..4
//   es_onehot : true when a button vector (zero-extended to 8 bits) is one-hot
//   valvula   : maps (category, drink) to the flat valve index
package dispensador_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MENU = 3'd1,
        S_SUB  = 3'd2,
        S_POUR = 3'd3,
        S_DENY = 3'd4
    } estado_t;

    function automatic logic es_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic int unsigned valvula(input int unsigned cat,
                                            input int unsigned bev,
                                            input int unsigned nbeb);
        return cat * nbeb + bev;
    endfunction

endpackage

// File: rtl/dispensador_temporizador.sv
// dispensador_temporizador: saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable; counting stops once lim is reached
//   lim        : terminal value
//   fin        : high while the count equals lim
module dispensador_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic         fin
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (en && cnt != lim)  cnt <= cnt + W'(1);
    end

    assign fin = (cnt == lim);

endmodule

// File: rtl/dispensador_bebidas_param.sv
// dispensador_bebidas_param: buffet drink dispenser, main menu + category
// sub-menu, timed pour, timed denial, age check and inactivity timeout.
//   clk, reset      : clock, asynchronous active-low reset
//   start, back     : confirm / return buttons
//   mayor           : valid adult ID presented
//   cat_sel/bev_sel : category / drink buttons (act only when one-hot)
//   display         : state code (0 IDLE, 1 MENU, 2 SUB, 3 POUR, 4 DENY)
//   cat_idx         : latched category
//   despacho        : one-hot valve enables
//   busy            : high in POUR or DENY
//   agotado         : per-drink out-of-stock flags (DISPENSADOR_STOCK_EN only)
// Optional feature macro: DISPENSADOR_STOCK_EN adds per-drink stock counters.
module dispensador_bebidas_param
    import dispensador_pkg::*;
#(
    parameter int              NCAT        = 4,
    parameter int              NBEB        = 2,
    parameter logic [NCAT-1:0] ALC_MASK    = NCAT'(1),
    parameter int              POUR_CYC    = 4,
    parameter int              DENY_CYC    = 2,
    parameter int              TIMEOUT_CYC = 16
`ifdef DISPENSADOR_STOCK_EN
    ,
    parameter int              STOCK_INIT  = 3
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       back,
    input  logic                       mayor,
    input  logic [NCAT-1:0]            cat_sel,
    input  logic [NBEB-1:0]            bev_sel,
    output logic [2:0]                 display,
    output logic [$clog2(NCAT)-1:0]    cat_idx,
    output logic [NCAT*NBEB-1:0]       despacho,
`ifdef DISPENSADOR_STOCK_EN
    output logic [NCAT*NBEB-1:0]       agotado,
`endif
    output logic                       busy
);
    localparam int CW = $clog2(NCAT);
    localparam int BW = $clog2(NBEB);
    localparam int NV = NCAT * NBEB;
    localparam int PW = $clog2(POUR_CYC + 1);
    localparam int DW = $clog2(DENY_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    estado_t       state, state_next;
    logic [CW-1:0] cat_q, cat_enc;
    logic [BW-1:0] bev_q, bev_enc;
    logic          age_ok, cat_oh, bev_oh, activity, chg;
    logic          pour_fin, deny_fin, to_fin;
    logic          sin_stock;

    assign cat_oh   = es_onehot(8'(cat_sel));
    assign bev_oh   = es_onehot(8'(bev_sel));
    assign activity = start | back | mayor | (|cat_sel) | (|bev_sel);
    assign chg      = (state != state_next);

    // Button index encoders; only consumed when the vector is one-hot.
    always_comb begin
        cat_enc = '0;
        for (int i = 0; i < NCAT; i++) if (cat_sel[i]) cat_enc = CW'(i);
        bev_enc = '0;
        for (int i = 0; i < NBEB; i++) if (bev_sel[i]) bev_enc = BW'(i);
    end

`ifdef DISPENSADOR_STOCK_EN
    localparam int SKW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    localparam int VIW = (NV > 1) ? $clog2(NV) : 1;

    logic [NV-1:0][SKW-1:0] stock;
    logic [VIW-1:0]         sel_v;

    assign sel_v     = VIW'(valvula(32'(cat_q), 32'(bev_enc), 32'(NBEB)));
    assign sin_stock = (stock[sel_v] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NV; i++) stock[i] <= SKW'(STOCK_INIT);
        end else if (state == S_SUB && state_next == S_POUR) begin
            stock[sel_v] <= stock[sel_v] - SKW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NV; i++) agotado[i] = (stock[i] == '0);
    end
`else
    assign sin_stock = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_MENU;
            S_MENU: begin
                if (cat_oh)                     state_next = S_SUB;
                else if (to_fin && !activity)   state_next = S_IDLE;
            end
            S_SUB: begin
                if (back)                       state_next = S_MENU;
                else if (start && bev_oh) begin
                    // mayor in the confirm cycle counts toward the age check.
                    if (ALC_MASK[cat_q] && !(age_ok || mayor)) state_next = S_DENY;
                    else if (sin_stock)                        state_next = S_DENY;
                    else                                       state_next = S_POUR;
                end
                else if (to_fin && !activity)   state_next = S_IDLE;
            end
            S_POUR: if (pour_fin) state_next = S_IDLE;
            S_DENY: if (deny_fin) state_next = S_SUB;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cat_q  <= '0;
            bev_q  <= '0;
            age_ok <= 1'b0;
        end else begin
            if (state == S_MENU && state_next == S_SUB)  cat_q <= cat_enc;
            if (state == S_SUB  && state_next == S_POUR) bev_q <= bev_enc;
            if (state != S_IDLE && state_next == S_IDLE) age_ok <= 1'b0;
            else if (state == S_SUB && mayor)            age_ok <= 1'b1;
        end
    end

    dispensador_temporizador #(.W(PW)) u_pour (
        .clk(clk), .reset(reset), .clr(chg), .en(state == S_POUR),
        .lim(PW'(POUR_CYC - 1)), .fin(pour_fin)
    );

    dispensador_temporizador #(.W(DW)) u_deny (
        .clk(clk), .reset(reset), .clr(chg), .en(state == S_DENY),
        .lim(DW'(DENY_CYC - 1)), .fin(deny_fin)
    );

    // Any button activity restarts the inactivity window.
    dispensador_temporizador #(.W(TW)) u_timeout (
        .clk(clk), .reset(reset), .clr(chg || activity),
        .en(state == S_MENU || state == S_SUB),
        .lim(TW'(TIMEOUT_CYC - 1)), .fin(to_fin)
    );

    assign display  = state;
    assign cat_idx  = cat_q;
    assign busy     = (state == S_POUR) || (state == S_DENY);
    assign despacho = (state == S_POUR)
                    ? (NV'(1) << valvula(32'(cat_q), 32'(bev_q), 32'(NBEB)))
                    : '0;

endmodule
